// File: rtl/seq_det_param_moore.sv
// Parametrised Moore serial sequence detector with KMP-style fallback,
// selectable overlap, sample-valid qualifier and a saturating match counter.
module seq_det_param_moore #(
  parameter int unsigned    N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in,
  input  logic                     clr_cnt,
  output logic                     det,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(N+1)-1:0]   prefix_len
);

  localparam int unsigned SW = $clog2(N+1);
  localparam int unsigned NS = 2**SW;
  localparam logic [SW-1:0] S_MATCH = SW'(N);

  // Next-state table for one input bit value, folded to constants at
  // elaboration. Entry k holds the longest pattern prefix that is a suffix
  // of (prefix_k, b); codes above N are unreachable and map to S0.
  function automatic logic [NS*SW-1:0] build_tab(input logic b);
    logic [NS*SW-1:0] t;
    int unsigned      best;
    logic             ok;
    logic             sb;
    t = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      best = 0;
      if (k == N && !OVERLAP) begin
        best = (b == PATTERN[N-1]) ? 1 : 0;
      end else begin
        for (int unsigned j = 1; j <= N; j++) begin
          if (j <= k + 1) begin
            ok = 1'b1;
            for (int unsigned m = 0; m < j; m++) begin
              // m counts back from the newest bit; older bits come from prefix_k
              sb = (m == 0) ? b : PATTERN[N-k+m-1];
              if (sb != PATTERN[N-j+m]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
      end
      t[k*SW +: SW] = SW'(best);
    end
    return t;
  endfunction

  localparam logic [NS*SW-1:0] NXT0 = build_tab(1'b0);
  localparam logic [NS*SW-1:0] NXT1 = build_tab(1'b1);

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;

  always_comb begin
    nxt = in ? NXT1[state*SW +: SW] : NXT0[state*SW +: SW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= '0;
      det       <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (in_valid) begin
        state <= nxt;
        det   <= (nxt == S_MATCH);
      end
      if (clr_cnt)
        match_cnt <= '0;
      else if (in_valid && nxt == S_MATCH && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
    end
  end

  assign prefix_len = state;

endmodule
